// File: rtl/sample_adder_top.sv
// sample_adder_top: pairs two independently-valid unsigned sample streams
// and emits their registered, one-bit-wider sum.
//
// Each input channel has a one-entry holding register. The sum fires on the
// cycle after both holds are full. A new sample arriving on a channel whose
// hold is still waiting replaces the older sample, so the newest one wins.
//
// Ports:
//   ref_clk   in   reference clock; the only clock
//   rst       in   synchronous active-high reset
//   clk_out   out  ref_clk forwarded combinationally
//   dinp_a    in   [DATA_W-1:0] operand A, with valid_a as its qualifier
//   dinp_b    in   [DATA_W-1:0] operand B, with valid_b as its qualifier
//   out       out  [DATA_W:0]   registered sum A+B
//   valid_out out  single-cycle qualifier for out

// One channel's holding register.
//   din/vld  incoming sample
//   consume  the pair fired this cycle, so the held sample is used up
//   hold/full  the held sample and its occupancy flag
module sample_hold #(
  parameter int DATA_W = 8
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              vld,
  input  logic              consume,
  output logic [DATA_W-1:0] hold,
  output logic              full
);
  logic [DATA_W-1:0] hold_d, hold_q;
  logic              full_d, full_q;

  // A refill takes priority over consume. It covers both a same-edge refill
  // and an overwrite of an unpaired sample.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (vld) begin
      hold_d = din;
      full_d = 1'b1;
    end else if (consume) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign hold = hold_q;
  assign full = full_q;
endmodule

module sample_adder_top #(
  parameter int DATA_W = 8
) (
  input  logic              ref_clk,
  input  logic              rst,
  output logic              clk_out,
  input  logic [DATA_W-1:0] dinp_a,
  input  logic              valid_a,
  input  logic [DATA_W-1:0] dinp_b,
  input  logic              valid_b,
  output logic [DATA_W:0]   out,
  output logic              valid_out
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][DATA_W-1:0] ch_din, ch_hold;
  logic [NUM_CH-1:0]             ch_vld, ch_full;
  logic                          fire;

  logic [DATA_W:0] out_d, out_q;
  logic            vo_d, vo_q;

  // Plain forward of the reference clock; it is not gated and it keeps
  // toggling through reset.
  assign clk_out = ref_clk;

  assign ch_din = {dinp_b, dinp_a};
  assign ch_vld = {valid_b, valid_a};
  assign fire   = &ch_full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sample_hold #(.DATA_W(DATA_W)) u_hold (
      .ref_clk (ref_clk),
      .rst     (rst),
      .din     (ch_din[c]),
      .vld     (ch_vld[c]),
      .consume (fire),
      .hold    (ch_hold[c]),
      .full    (ch_full[c])
    );
  end

  // Both operands are zero-extended before the add, so the carry lands in
  // the MSB and the sum can never overflow.
  always_comb begin
    out_d = out_q;
    vo_d  = 1'b0;
    if (fire) begin
      out_d = {1'b0, ch_hold[0]} + {1'b0, ch_hold[1]};
      vo_d  = 1'b1;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      out_q <= '0;
      vo_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      vo_q  <= vo_d;
    end
  end

  assign out       = out_q;
  assign valid_out = vo_q;
endmodule

// File: tb/tb_sample_adder_top.sv
module tb_sample_adder_top;
  logic       ref_clk = 1'b0;
  logic       rst;
  logic       clk_out;
  logic [7:0] dinp_a, dinp_b;
  logic       valid_a, valid_b;
  logic [8:0] out;
  logic       valid_out;

  int checks = 0;
  int errors = 0;

  always #5 ref_clk = ~ref_clk;

  sample_adder_top #(.DATA_W(8)) dut (
    .ref_clk   (ref_clk),
    .rst       (rst),
    .clk_out   (clk_out),
    .dinp_a    (dinp_a),
    .valid_a   (valid_a),
    .dinp_b    (dinp_b),
    .valid_b   (valid_b),
    .out       (out),
    .valid_out (valid_out)
  );

  // One record per clock. The inputs are presented for the cycle, and the
  // expected outputs are sampled just after the edge that captures them.
  typedef struct {
    string      name;
    logic       rst;
    logic       va;
    logic [7:0] a;
    logic       vb;
    logic [7:0] b;
    logic       evo;
    logic [8:0] eout;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string n, logic r, logic va, logic [7:0] a,
                              logic vb, logic [7:0] b, logic evo, logic [8:0] eout);
    vec_t v;
    v.name = n; v.rst = r; v.va = va; v.a = a; v.vb = vb; v.b = b;
    v.evo = evo; v.eout = eout;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic apply(int i);
    rst = tbl[i].rst;
    valid_a = tbl[i].va; dinp_a = tbl[i].a;
    valid_b = tbl[i].vb; dinp_b = tbl[i].b;
    step();
    check({tbl[i].name, "_vo"},  {8'd0, valid_out}, {8'd0, tbl[i].evo});
    check({tbl[i].name, "_out"}, out, tbl[i].eout);
  endtask

  logic [8:0] exp_sum;

  initial begin
    // Reset for 3 cycles with both channels driven valid.
    add("rst0", 1, 1, 8'h55, 1, 8'h66, 0, 9'h000);
    add("rst1", 1, 1, 8'h55, 1, 8'h66, 0, 9'h000);
    add("rst2", 1, 1, 8'h55, 1, 8'h66, 0, 9'h000);
    // Max operands. The previous output is the last streaming sum, 44+45=89.
    add("max_cap",  0, 1, 8'hFF, 1, 8'hFF, 0, 9'd89);
    add("max_sum",  0, 1, 8'hFF, 1, 8'h01, 1, 9'h1FE);
    add("max_100",  0, 0, 8'h00, 0, 8'h00, 1, 9'h100);
    add("max_idle", 0, 0, 8'h00, 0, 8'h00, 0, 9'h100);
    // Skewed pairing: A=10, then B=20 three cycles later.
    add("skw_a",  0, 1, 8'd10, 0, 8'd0,  0, 9'h100);
    add("skw_1",  0, 0, 8'd0,  0, 8'd0,  0, 9'h100);
    add("skw_2",  0, 0, 8'd0,  0, 8'd0,  0, 9'h100);
    add("skw_b",  0, 0, 8'd0,  1, 8'd20, 0, 9'h100);
    add("skw_s",  0, 0, 8'd0,  0, 8'd0,  1, 9'd30);
    add("skw_i",  0, 0, 8'd0,  0, 8'd0,  0, 9'd30);
    // Overwrite: A=5 is replaced by A=7 before B arrives.
    add("ovw_a5", 0, 1, 8'd5, 0, 8'd0, 0, 9'd30);
    add("ovw_a7", 0, 1, 8'd7, 0, 8'd0, 0, 9'd30);
    add("ovw_b1", 0, 0, 8'd0, 1, 8'd1, 0, 9'd30);
    add("ovw_s",  0, 0, 8'd0, 0, 8'd0, 1, 9'd8);
    add("ovw_i",  0, 0, 8'd0, 0, 8'd0, 0, 9'd8);
    // Reset mid-pair: the pending A is discarded.
    add("rmp_a9", 0, 1, 8'd9, 0, 8'd0, 0, 9'd8);
    add("rmp_r",  1, 0, 8'd0, 0, 8'd0, 0, 9'd0);
    add("rmp_b1", 0, 0, 8'd0, 1, 8'd1, 0, 9'd0);
    add("rmp_i",  0, 0, 8'd0, 0, 8'd0, 0, 9'd0);
    add("rmp_ab", 0, 1, 8'd2, 1, 8'd3, 0, 9'd0);
    add("rmp_s",  0, 0, 8'd0, 0, 8'd0, 1, 9'd5);
    add("rmp_i2", 0, 0, 8'd0, 0, 8'd0, 0, 9'd5);
    // Reset while a pair is full: the in-flight sum never appears.
    add("rif_ab", 0, 1, 8'd1, 1, 8'd1, 0, 9'd5);
    add("rif_r",  1, 0, 8'd0, 0, 8'd0, 0, 9'd0);
    add("rif_i",  0, 0, 8'd0, 0, 8'd0, 0, 9'd0);

    rst = 1; valid_a = 0; valid_b = 0; dinp_a = 0; dinp_b = 0;
    for (int i = 0; i < 3; i++) apply(i);

    // clk_out follows ref_clk during reset.
    check("clk_out_hi", {8'd0, clk_out}, 9'd1);
    @(negedge ref_clk); #1;
    check("clk_out_lo", {8'd0, clk_out}, 9'd0);
    step();

    // Streaming with incrementing counters (they wrap at 256). The sum for
    // the pair captured one edge earlier shows up on each edge.
    for (int i = 0; i < 300; i++) begin
      rst = 0;
      valid_a = 1; dinp_a = 8'((i + 1) % 256);
      valid_b = 1; dinp_b = 8'((i + 2) % 256);
      exp_sum = 9'(((i % 256) + ((i + 1) % 256)));
      step();
      if (i == 0) begin
        check("strm_first_vo", {8'd0, valid_out}, 9'd0);
      end else begin
        check("strm_vo", {8'd0, valid_out}, 9'd1);
        check("strm_out", out, exp_sum);
      end
    end
    valid_a = 0; valid_b = 0;
    step();
    check("strm_last_vo", {8'd0, valid_out}, 9'd1);
    check("strm_last_out", out, 9'd89);
    step();
    check("strm_end_vo", {8'd0, valid_out}, 9'd0);

    for (int i = 3; i < tbl.size(); i++) apply(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
